ram_dp_arbiter: RTL and testbench

//  Round-robin arbiter sharing the 64x8 dual-port RAM between N_REQ requesters.

---
 rtl/ram_dp_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_dp_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_arbiter.sv
// Round-robin arbiter sharing a dual-port RAM between N_REQ requesters.
// Up to two grants per cycle (ports A and B); read data is routed back by requester id.
`timescale 1ns/1ps
module ram_dp_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ-1:0]        REQ_WE,
  input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
  output logic [N_REQ-1:0]        GNT,
  output logic [N_REQ-1:0]        RVALID,
  output logic [N_REQ*DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0]       ADDR_A,
  output logic [ADDR_W-1:0]       ADDR_B,
  output logic [DATA_W-1:0]       DATA_A,
  output logic [DATA_W-1:0]       DATA_B,
  output logic                    WE_A,
  output logic                    WE_B,
  input  logic [DATA_W-1:0]       Q_A,
  input  logic [DATA_W-1:0]       Q_B
);
  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] ptr_p0;
  logic            vld_a_p0, vld_b_p0;
  logic [ID_W-1:0] id_a_p0, id_b_p0;
  logic            vld_a_p1, vld_b_p1;
  logic [ID_W-1:0] id_a_p1, id_b_p1;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + ID_W'(1);
  endfunction

  // Stage p0: scan from the pointer; B skips requesters that collide with A's address
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            clash;
    vld_a_p0 = 1'b0;
    vld_b_p0 = 1'b0;
    id_a_p0  = '0;
    id_b_p0  = '0;
    idx      = '0;
    clash    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = ID_W'((int'(ptr_p0) + k) % N_REQ);
      clash = vld_a_p0 &&
              (REQ_ADDR[idx*ADDR_W +: ADDR_W] == REQ_ADDR[id_a_p0*ADDR_W +: ADDR_W]) &&
              (REQ_WE[idx] || REQ_WE[id_a_p0]);
      if (REQ[idx] && !vld_a_p0) begin
        vld_a_p0 = 1'b1;
        id_a_p0  = idx;
      end else if (REQ[idx] && !vld_b_p0 && !clash) begin
        vld_b_p0 = 1'b1;
        id_b_p0  = idx;
      end
    end
  end

  always_comb begin
    GNT    = '0;
    WE_A   = 1'b0;
    ADDR_A = '0;
    DATA_A = '0;
    WE_B   = 1'b0;
    ADDR_B = '0;
    DATA_B = '0;
    if (vld_a_p0) begin
      GNT[id_a_p0] = 1'b1;
      WE_A   = REQ_WE[id_a_p0];
      ADDR_A = REQ_ADDR[id_a_p0*ADDR_W +: ADDR_W];
      DATA_A = REQ_DATA[id_a_p0*DATA_W +: DATA_W];
    end
    if (vld_b_p0) begin
      GNT[id_b_p0] = 1'b1;
      WE_B   = REQ_WE[id_b_p0];
      ADDR_B = REQ_ADDR[id_b_p0*ADDR_W +: ADDR_W];
      DATA_B = REQ_DATA[id_b_p0*DATA_W +: DATA_W];
    end
  end

  // Stage p1: advance pointer past the last grant, tag ports carrying reads
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_p0   <= '0;
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
    end else begin
      if (vld_b_p0)      ptr_p0 <= wrap_inc(id_b_p0);
      else if (vld_a_p0) ptr_p0 <= wrap_inc(id_a_p0);
      vld_a_p1 <= vld_a_p0 && !REQ_WE[id_a_p0];
      vld_b_p1 <= vld_b_p0 && !REQ_WE[id_b_p0];
    end
  end

  always_ff @(posedge CLK) begin
    id_a_p1 <= id_a_p0;
    id_b_p1 <= id_b_p0;
  end

  // Stage p2: RAM output is valid now; steer it to the tagged requester
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RVALID <= '0;
      RDATA  <= '0;
    end else begin
      RVALID <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        if (vld_a_p1 && int'(id_a_p1) == k) begin
          RVALID[k]                  <= 1'b1;
          RDATA[k*DATA_W +: DATA_W] <= Q_A;
        end
        if (vld_b_p1 && int'(id_b_p1) == k) begin
          RVALID[k]                  <= 1'b1;
          RDATA[k*DATA_W +: DATA_W] <= Q_B;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter: directed scenarios plus randomized traffic against a
// scan-order reference model and a behavioural 64x8 dual-port RAM.
`timescale 1ns/1ps
module tb_ram_dp_arbiter;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  REQ, REQ_WE;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]  GNT, RVALID;
  logic [N*DW-1:0] RDATA;
  logic [AW-1:0] ADDR_A, ADDR_B;
  logic [DW-1:0] DATA_A, DATA_B, Q_A, Q_B;
  logic          WE_A, WE_B;

  always #5 CLK = ~CLK;

  ram_dp_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .DATA_A(DATA_A), .DATA_B(DATA_B),
    .WE_A(WE_A), .WE_B(WE_B), .Q_A(Q_A), .Q_B(Q_B));

  // Behavioural dual-port RAM, read-first, one cycle read latency
  logic [DW-1:0] ram [64] = '{default: '0};
  always @(posedge CLK) begin
    if (WE_A) ram[ADDR_A] <= DATA_A;
    if (WE_B) ram[ADDR_B] <= DATA_B;
    Q_A <= ram[ADDR_A];
    Q_B <= ram[ADDR_B];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int              m_ptr = 0;
  logic [DW-1:0]   m_mem [64] = '{default: '0};
  logic [N-1:0]    m_pend = '0;
  logic [N*DW-1:0] m_pend_d = '0;
  logic [N*DW-1:0] m_rdata = '0;
  logic [N-1:0]    last_gnt = '0;
  logic [N-1:0]    obs_gnt = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return REQ_ADDR[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return REQ_DATA[i*DW +: DW];
  endfunction

  // Visit requesters in round-robin order from the pointer; A is the first
  // requester, B the first later one that does not collide with A.
  task automatic model_pick(output int a, output int b);
    int order[$];
    int j;
    a = -1;
    b = -1;
    for (int k = 0; k < N; k++)
      if (REQ[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    if (order.size() > 0) a = order[0];
    for (int k = 1; k < order.size(); k++) begin
      j = order[k];
      if (!((addr_of(j) == addr_of(a)) && (REQ_WE[j] || REQ_WE[a]))) begin
        b = j;
        break;
      end
    end
  endtask

  // One clock: called just after a negedge with inputs set, returns at the next negedge
  task automatic cycle(input string tag);
    int a, b;
    logic [N-1:0]    eg, np;
    logic [N*DW-1:0] nd;
    logic [AW+DW:0]  pa, pb;
    #1;
    model_pick(a, b);
    eg = '0; np = '0; nd = '0; pa = '0; pb = '0;
    obs_gnt = GNT;
    if (a >= 0) begin eg[a] = 1'b1; pa = {REQ_WE[a], addr_of(a), data_of(a)}; end
    if (b >= 0) begin eg[b] = 1'b1; pb = {REQ_WE[b], addr_of(b), data_of(b)}; end
    check_val({tag, ".gnt"}, 64'(GNT), 64'(eg));
    check_val({tag, ".porta"}, 64'({WE_A, ADDR_A, DATA_A}), 64'(pa));
    check_val({tag, ".portb"}, 64'({WE_B, ADDR_B, DATA_B}), 64'(pb));
    if (a >= 0 && !REQ_WE[a]) begin np[a] = 1'b1; nd[a*DW +: DW] = m_mem[addr_of(a)]; end
    if (b >= 0 && !REQ_WE[b]) begin np[b] = 1'b1; nd[b*DW +: DW] = m_mem[addr_of(b)]; end
    if (a >= 0 && REQ_WE[a]) m_mem[addr_of(a)] = data_of(a);
    if (b >= 0 && REQ_WE[b]) m_mem[addr_of(b)] = data_of(b);
    if (b >= 0) m_ptr = (b + 1) % N;
    else if (a >= 0) m_ptr = (a + 1) % N;
    last_gnt = eg;
    @(posedge CLK);
    #1;
    for (int k = 0; k < N; k++)
      if (m_pend[k]) m_rdata[k*DW +: DW] = m_pend_d[k*DW +: DW];
    check_val({tag, ".rvalid"}, 64'(RVALID), 64'(m_pend));
    check_val({tag, ".rdata"}, 64'(RDATA), 64'(m_rdata));
    m_pend   = np;
    m_pend_d = nd;
    @(negedge CLK);
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input int data);
    REQ[i]                = 1'b1;
    REQ_WE[i]             = we;
    REQ_ADDR[i*AW +: AW]  = AW'(addr);
    REQ_DATA[i*DW +: DW]  = DW'(data);
  endtask

  task automatic rand_phase(input int ncyc, input bit reads_only, output int max_wait);
    int waitc[N];
    for (int i = 0; i < N; i++) waitc[i] = 0;
    max_wait = 0;
    REQ = '0;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!REQ[i] || last_gnt[i]) begin
          REQ[i]               = ($urandom_range(0, 3) != 0);
          REQ_WE[i]            = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
          REQ_ADDR[i*AW +: AW] = AW'($urandom_range(8, 15));
          REQ_DATA[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
      end
      cycle(reads_only ? "rnd_rd" : "rnd_mix");
      for (int i = 0; i < N; i++) begin
        if (REQ[i] && last_gnt[i]) begin
          if (waitc[i] > max_wait) max_wait = waitc[i];
          waitc[i] = 0;
        end else if (REQ[i]) begin
          waitc[i]++;
        end
      end
    end
    REQ = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int mw;
    REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_DATA = '0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_val("rst.rvalid", 64'(RVALID), 64'(0));
    check_val("rst.rdata", 64'(RDATA), 64'(0));
    check_val("rst.gnt", 64'(GNT), 64'(0));
    RST_N = 1'b1;
    @(negedge CLK);

    // T2: write then read back
    set_req(0, 1'b1, 5, 8'h2A);
    cycle("t2w");
    check_val("t2w.gnt", 64'(obs_gnt), 64'(4'b0001));
    REQ = '0;
    set_req(0, 1'b0, 5, 0);
    cycle("t2r");
    REQ = '0;
    cycle("t2i");
    check_val("t2.rvalid", 64'(RVALID), 64'(4'b0001));
    check_val("t2.rdata0", 64'(RDATA[7:0]), 64'(8'h2A));

    // T3: two reads in parallel
    set_req(1, 1'b1, 3, 8'h11);
    set_req(2, 1'b1, 9, 8'h22);
    cycle("t3w");
    REQ = '0;
    set_req(1, 1'b0, 3, 0);
    set_req(2, 1'b0, 9, 0);
    cycle("t3r");
    check_val("t3.gnt", 64'(obs_gnt), 64'(4'b0110));
    REQ = '0;
    cycle("t3i");
    check_val("t3.rvalid", 64'(RVALID), 64'(4'b0110));
    check_val("t3.rdata1", 64'(RDATA[15:8]), 64'(8'h11));
    check_val("t3.rdata2", 64'(RDATA[23:16]), 64'(8'h22));

    // T4: write/read collision on one address, pointer brought to 0 first
    set_req(3, 1'b0, 0, 0);
    cycle("t4p");
    REQ = '0;
    set_req(0, 1'b1, 7, 8'h5C);
    set_req(1, 1'b0, 7, 0);
    cycle("t4c1");
    check_val("t4.gnt1", 64'(obs_gnt), 64'(4'b0001));
    REQ[0] = 1'b0;
    cycle("t4c2");
    check_val("t4.gnt2", 64'(obs_gnt), 64'(4'b0010));
    REQ = '0;
    cycle("t4i");
    check_val("t4.rdata1", 64'(RDATA[15:8]), 64'(8'h5C));

    // T5: all four requesting, pairs alternate; pointer from 2 to 0 via requester 3
    set_req(3, 1'b0, 3, 0);
    cycle("t5p");
    REQ = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
    for (int c = 0; c < 4; c++) begin
      cycle("t5");
      check_val("t5.pair", 64'(obs_gnt), 64'((c % 2 == 0) ? 4'b0011 : 4'b1100));
    end
    REQ = '0;

    // T6: wrap from pointer 3
    set_req(2, 1'b0, 2, 0);
    cycle("t6p");
    REQ = '0;
    set_req(3, 1'b0, 3, 0);
    set_req(0, 1'b0, 0, 0);
    cycle("t6w");
    check_val("t6.gnt", 64'(obs_gnt), 64'(4'b1001));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
    cycle("t6n");
    check_val("t6.ptr1", 64'(obs_gnt), 64'(4'b0110));
    REQ = '0;
    cycle("t6i");

    rand_phase(1000, 1'b1, mw);
    check_val("t6.fair", 64'(mw <= 3), 64'(1));
    rand_phase(1000, 1'b0, mw);
    cycle("rnd_end");

    // T1: reset with a read in flight
    set_req(0, 1'b0, 5, 0);
    cycle("t1a");
    REQ = '0;
    cycle("t1b");
    check_val("t1.pre", 64'(RDATA[7:0]), 64'(8'h2A));
    set_req(0, 1'b0, 5, 0);
    cycle("t1rd");
    REQ = '0;
    RST_N = 1'b0;
    #1;
    check_val("t1.rvalid", 64'(RVALID), 64'(0));
    check_val("t1.rdata", 64'(RDATA), 64'(0));
    m_ptr = 0; m_pend = '0; m_pend_d = '0; m_rdata = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    cycle("t1post");
    check_val("t1.nostrobe", 64'(RVALID), 64'(0));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
    cycle("t1ptr");
    check_val("t1.ptr0", 64'(obs_gnt), 64'(4'b0011));
    REQ = '0;
    cycle("t1end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
